// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux (select + one-hot grant), with bounded hold; MUX4_ARB_LOCK_EN adds a lock input.
// Latency: grant registered one cycle after a request is sampled; every release/preemption inserts one dead cycle.
// Backpressure: requesters hold req high while they need the mux; non-owners wait until the next arbitration point.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
`ifdef MUX4_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [3:0]       gnt,
  output logic [1:0]       s,
  output logic             valid,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  // With the timeout disabled the counter simply saturates at its top value.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       gnt_d;
  logic [1:0]       s_d;
  logic             valid_d;
  logic [CNT_W-1:0] hold_d;
  logic [1:0]       pick;
  logic             lock_act;
  logic             timeout;

`ifdef MUX4_ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // Scan from farthest to nearest so the requester closest after ptr wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick    = rr_pick(req, ptr_q);
  assign timeout = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) &&
                   (|(req & ~gnt)) && !lock_act;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    s_d     = s;
    valid_d = valid;
    hold_d  = hold_cnt;
    case (state_q)
      IDLE, GAP: begin
        hold_d = '0;
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick;
          s_d     = pick;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        // Release wins over a coincident timeout; both land in GAP identically.
        if (!req[s] || timeout) begin
          state_d = GAP;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          hold_d  = '0;
          ptr_d   = s;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_d = hold_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd3;
      gnt      <= 4'b0000;
      s        <= 2'd0;
      valid    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt      <= gnt_d;
      s        <= s_d;
      valid    <= valid_d;
      hold_cnt <= hold_d;
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 multiplexer datapath between four requesters.
- Drives the mux select S[1:0] and a one-hot grant vector.
- Enforces a bounded hold time so that no requester can starve the others.
- Sits directly in front of the 4:1 mux; requester i owns mux input I[i] while granted.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT cycles per owner before preemption when others wait; 0 disables the timeout.
- CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- CLK, input, 1, rising-edge clock.
- RST_N, input, 1, asynchronous active-low reset.
- REQ, input, 4, request per requester; held high for the whole time the mux is needed.
- GNT, output, 4, one-hot grant, registered.
- S, output, 2, mux select = index of current or last owner, registered.
- VALID, output, 1, high when any GNT bit is high (mux output meaningful).
- HOLD_CNT, output, CNT_W, cycles the current owner has held the grant (debug).

Behaviour:
- Interface decided: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values: GNT=0000, S=00, VALID=0, HOLD_CNT=0, state=IDLE, priority pointer PTR=3 (first search starts at requester 0).
- States: IDLE, GRANT, GAP. All outputs are registered.
- Selection function: search REQ starting at (PTR+1) mod 4, wrapping, first set bit wins.
- IDLE:
  - If REQ != 0, go to GRANT next edge with owner = selection.
  - GNT, S and VALID update on that same edge, so grant latency is one cycle from REQ sampled high.
  - If REQ == 0, stay in IDLE.
- GRANT:
  - If REQ[owner]=0, go to GAP; GNT cleared on that edge; PTR := owner.
  - Else if MAX_HOLD != 0, HOLD_CNT == MAX_HOLD-1, and some REQ other than owner is high: preempt. Go to GAP, GNT cleared, PTR := owner.
  - Else stay; HOLD_CNT increments and saturates at MAX_HOLD-1.
  - If only the owner is requesting, there is no preemption and it holds indefinitely.
- GAP:
  - Lasts exactly one cycle with GNT=0 and VALID=0 (break-before-make, no glitch on the shared output).
  - If REQ != 0, go to GRANT with a new owner via the selection function.
  - A preempted owner still requesting is eligible but has lowest priority.
  - Otherwise go to IDLE.
- HOLD_CNT:
  - Cleared to 0 on every entry to GRANT.
  - 0 in IDLE and GAP.
  - Counts 0..MAX_HOLD-1 in GRANT.
- S:
  - Loads the owner index on entry to GRANT.
  - Holds its value in GAP and IDLE (no toggling while idle).
- Invariants: GNT is one-hot or zero at all times; S equals the index of the set GNT bit whenever VALID=1.
- Simultaneous events: if the owner drops REQ on the same cycle a timeout would fire, treat it as a release (same resulting state, PTR := owner).
- REQ bits of non-owners changing mid-grant have no effect until the next arbitration point.
- Reset mid-operation: immediately clears all outputs and state asynchronously; the first grant after release follows the 0,1,2,3 order.

Optional Feature:
- Macro: MUX4_ARB_LOCK_EN.
- Defined:
  - Adds input LOCK (1 bit).
  - While in GRANT with LOCK=1, timeout preemption is suppressed and HOLD_CNT saturates.
  - Release via REQ[owner]=0 still applies.
  - LOCK is ignored outside GRANT.
- Undefined:
  - No LOCK port.
  - Timeout preemption is always active per MAX_HOLD.

Test Plan:
- Reset, then REQ=0100 at cycle 0: GNT=0100, S=10, VALID=1 at cycle 1; REQ=0000 at cycle 3 gives GNT=0000 at cycle 4 (GAP), then IDLE.
- REQ=1111 held, MAX_HOLD=4: grants in order 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 cycles followed by one GAP cycle; S follows 0,1,2,3,0.
- REQ=0001 alone held for 40 cycles: GNT stays 0001, HOLD_CNT saturates at 3 (MAX_HOLD=4), and no GAP occurs.
- Owner 2 releases while REQ=1011: the next grant is 1000 (search starts at 3), then 0001, then 0010.
- Assert RST_N=0 mid-GRANT (GNT=0010): outputs clear asynchronously before the next CLK edge; after release, REQ=1010 grants 0010 first.
- With MUX4_ARB_LOCK_EN defined, REQ=0011, owner 0, LOCK=1 for 10 cycles: no preemption. Drop LOCK: GAP at HOLD_CNT=3, then GNT=0010.
